// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN result transmitter slice.
package cnn_pkg;

    typedef enum logic [1:0] {
        ACCUM,
        SEND,
        WAIT,
        FIN
    } state_t;

    localparam int unsigned FRAME_LEN    = 5;
    localparam logic [7:0]  DEF_HDR_BYTE = 8'hA5;
    localparam int unsigned IDX_BYTE_W   = 7;

    // Class-index width; never narrower than one bit.
    function automatic int unsigned cls_idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cnn_result_tx_if.sv
// Score stream in, UART byte handshake out, plus frame status.
interface cnn_result_tx_if #(
    parameter int unsigned SCORE_W = 16
);
    logic                      score_vld;
    logic signed [SCORE_W-1:0] score;
    logic                      score_last;
    logic                      busy;
    logic                      trmt;
    logic [7:0]                tx_data;
    logic                      tx_done;
    logic                      frame_done;

    modport master (
        output score_vld, score, score_last, tx_done,
        input  busy, trmt, tx_data, frame_done
    );

    modport slave (
        input  score_vld, score, score_last, tx_done,
        output busy, trmt, tx_data, frame_done
    );
endinterface

// File: rtl/cnn_argmax.sv
// Running signed argmax over one image's scores with saturating count and overflow error.
module cnn_argmax
    import cnn_pkg::*;
#(
    parameter  int unsigned NUM_CLASSES = 10,
    parameter  int unsigned SCORE_W     = 16,
    localparam int unsigned IDX_W       = cls_idx_w(NUM_CLASSES),
    localparam int unsigned CNT_W       = $clog2(NUM_CLASSES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      vld,
    input  logic signed [SCORE_W-1:0] score,
    output logic        [IDX_W-1:0]   best_idx,
    output logic signed [SCORE_W-1:0] best_val,
    output logic        [CNT_W-1:0]   count,
    output logic                      err
);

    logic in_range;
    assign in_range = (count < CNT_W'(NUM_CLASSES));

    // Ties keep the earlier index; scores beyond NUM_CLASSES only flag err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_idx <= '0;
            best_val <= '0;
            count    <= '0;
            err      <= 1'b0;
        end else if (clr) begin
            count <= '0;
            err   <= 1'b0;
        end else if (vld) begin
            if (count == '0) begin
                best_val <= score;
                best_idx <= '0;
            end else if (in_range && (score > best_val)) begin
                best_val <= score;
                best_idx <= IDX_W'(count);
            end
            if (in_range) begin
                count <= count + 1'b1;
            end else begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnn_result_tx.sv
// Collects per-class scores, then sends a 5-byte argmax frame over the UART trmt/tx_done handshake.
module cnn_result_tx
    import cnn_pkg::*;
#(
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned SCORE_W     = 16,
    parameter logic [7:0]  HDR_BYTE    = DEF_HDR_BYTE
) (
    input logic           clk,
    input logic           rst,
    cnn_result_tx_if.slave bus
);

    localparam int unsigned IDX_W  = cls_idx_w(NUM_CLASSES);
    localparam int unsigned CNT_W  = $clog2(NUM_CLASSES + 1);
    localparam int unsigned BCNT_W = $clog2(FRAME_LEN);

    state_t                    state;
    logic [BCNT_W-1:0]         byte_cnt;
    logic [FRAME_LEN-2:0][7:0] frame_q;
    logic                      busy_q;
    logic                      trmt_q;
    logic [7:0]                tx_data_q;
    logic                      frame_done_q;

    logic                      accept;
    logic [IDX_W-1:0]          best_idx;
    logic signed [SCORE_W-1:0] best_val;
    logic [CNT_W-1:0]          count;
    logic                      err;

    assign accept = (state == ACCUM) && bus.score_vld;

    cnn_argmax #(
        .NUM_CLASSES(NUM_CLASSES),
        .SCORE_W    (SCORE_W)
    ) u_argmax (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == FIN),
        .vld     (accept),
        .score   (bus.score),
        .best_idx(best_idx),
        .best_val(best_val),
        .count   (count),
        .err     (err)
    );

    // Frame payload from the argmax registers, which have absorbed the last score by SEND.
    logic signed [15:0] val16;
    logic [7:0]         b1_c;
    logic [7:0]         b4_c;
    assign val16 = 16'(best_val);
    assign b1_c  = {err | (count != CNT_W'(NUM_CLASSES)), IDX_BYTE_W'(best_idx)};
    assign b4_c  = HDR_BYTE ^ b1_c ^ val16[15:8] ^ val16[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ACCUM;
            byte_cnt     <= '0;
            frame_q      <= '0;
            busy_q       <= 1'b0;
            trmt_q       <= 1'b0;
            tx_data_q    <= 8'h00;
            frame_done_q <= 1'b0;
        end else begin
            trmt_q       <= 1'b0;
            frame_done_q <= 1'b0;
            case (state)
                ACCUM: begin
                    if (accept && bus.score_last) begin
                        state     <= SEND;
                        busy_q    <= 1'b1;
                        trmt_q    <= 1'b1;
                        tx_data_q <= HDR_BYTE;
                        byte_cnt  <= '0;
                    end
                end
                SEND: begin
                    state <= WAIT;
                    if (byte_cnt == '0) begin
                        frame_q <= {b4_c, val16[7:0], val16[15:8], b1_c};
                    end
                end
                WAIT: begin
                    if (bus.tx_done) begin
                        if (byte_cnt == BCNT_W'(FRAME_LEN - 1)) begin
                            state        <= FIN;
                            frame_done_q <= 1'b1;
                        end else begin
                            state     <= SEND;
                            byte_cnt  <= byte_cnt + 1'b1;
                            trmt_q    <= 1'b1;
                            tx_data_q <= frame_q[byte_cnt[1:0]];
                        end
                    end
                end
                FIN: begin
                    state    <= ACCUM;
                    busy_q   <= 1'b0;
                    byte_cnt <= '0;
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.trmt       = trmt_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_cnn_result_tx.sv
// Directed bench for cnn_result_tx with a fixed-latency UART responder.
module tb_cnn_result_tx;

    localparam int unsigned SW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cnn_result_tx_if #(.SCORE_W(SW)) bus ();

    cnn_result_tx #(
        .NUM_CLASSES(10),
        .SCORE_W    (SW),
        .HDR_BYTE   (8'hA5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic uart_done  = 1'b0;
    logic stray_done = 1'b0;
    assign bus.tx_done = uart_done | stray_done;

    int tests = 0;
    int fails = 0;

    logic [7:0] cap [0:63];
    int ncap     = 0;
    int cd       = 0;
    int cyc      = 0;
    int done_cyc = 0;
    int fd_cyc   = 0;
    int fd_cnt   = 0;
    int img [16];

    always @(posedge clk) cyc <= cyc + 1;

    // UART model: capture each trmt byte, answer tx_done 20 cycles later.
    always @(negedge clk) begin
        uart_done = 1'b0;
        if (bus.frame_done === 1'b1) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        if (rst) begin
            cd = 0;
        end else if (bus.trmt === 1'b1) begin
            if (ncap < 64) cap[ncap] = bus.tx_data;
            ncap++;
            cd = 20;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                uart_done = 1'b1;
                done_cyc  = cyc;
            end
        end
    end

    task automatic drive_image(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.score_vld  = 1'b1;
            bus.score      = SW'(img[i]);
            bus.score_last = (i == n - 1);
        end
        @(negedge clk);
        bus.score_vld  = 1'b0;
        bus.score_last = 1'b0;
    endtask

    task automatic wait_frame(input int fd0, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            if (fd_cnt > fd0) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        tests++; if (bus.trmt !== 1'b0) begin fails++; $display("FAIL reset_trmt got %b want 0", bus.trmt); end
        tests++; if (bus.tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data got %h want 00", bus.tx_data); end
        tests++; if (bus.frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done got %b want 0", bus.frame_done); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_frame();
        logic [7:0] exp [5] = '{8'hA5, 8'h02, 8'h00, 8'h07, 8'hA0};
        int n0 = ncap;
        int f0 = fd_cnt;
        bit ok;
        img = '{-5, 3, 7, 7, -1, 0, 2, 6, 1, -8, 0, 0, 0, 0, 0, 0};
        drive_image(10);
        tests++; if (bus.trmt !== 1'b1 || bus.tx_data !== 8'hA5) begin fails++; $display("FAIL basic_latency trmt=%b data=%h want 1/a5", bus.trmt, bus.tx_data); end
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL basic_busy got %b want 1", bus.busy); end
        @(negedge clk);
        tests++; if (bus.trmt !== 1'b0) begin fails++; $display("FAIL basic_trmt_pulse got %b want 0", bus.trmt); end
        wait_frame(f0, ok);
        tests++; if (!ok) begin fails++; $display("FAIL basic_timeout frame_done count %0d want %0d", fd_cnt, f0 + 1); end
        tests++; if (fd_cyc !== done_cyc + 1) begin fails++; $display("FAIL basic_fd_timing got cycle %0d want %0d", fd_cyc, done_cyc + 1); end
        repeat (30) @(negedge clk);
        tests++; if (ncap - n0 !== 5) begin fails++; $display("FAIL basic_trmt_count got %0d want 5", ncap - n0); end
        tests++; if (fd_cnt - f0 !== 1) begin fails++; $display("FAIL basic_fd_count got %0d want 1", fd_cnt - f0); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL basic_idle_busy got %b want 0", bus.busy); end
        for (int k = 0; k < 5; k++) begin
            tests++; if (cap[n0 + k] !== exp[k]) begin fails++; $display("FAIL basic_byte%0d got %h want %h", k, cap[n0 + k], exp[k]); end
        end
    endtask

    task automatic test_most_negative();
        logic [7:0] exp [5] = '{8'hA5, 8'h00, 8'h80, 8'h00, 8'h25};
        int n0 = ncap;
        int f0 = fd_cnt;
        bit ok;
        for (int i = 0; i < 16; i++) img[i] = -32768;
        drive_image(10);
        wait_frame(f0, ok);
        tests++; if (!ok) begin fails++; $display("FAIL neg_timeout frame_done count %0d want %0d", fd_cnt, f0 + 1); end
        repeat (5) @(negedge clk);
        tests++; if (ncap - n0 !== 5) begin fails++; $display("FAIL neg_trmt_count got %0d want 5", ncap - n0); end
        for (int k = 0; k < 5; k++) begin
            tests++; if (cap[n0 + k] !== exp[k]) begin fails++; $display("FAIL neg_byte%0d got %h want %h", k, cap[n0 + k], exp[k]); end
        end
    endtask

    task automatic test_short_image();
        logic [7:0] exp [5] = '{8'hA5, 8'h84, 8'h01, 8'h23, 8'h03};
        int n0 = ncap;
        int f0 = fd_cnt;
        bit ok;
        img = '{0, 1, 2, 3, 291, 5, 6, 7, 0, 0, 0, 0, 0, 0, 0, 0};
        drive_image(8);
        wait_frame(f0, ok);
        tests++; if (!ok) begin fails++; $display("FAIL short_timeout frame_done count %0d want %0d", fd_cnt, f0 + 1); end
        repeat (5) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            tests++; if (cap[n0 + k] !== exp[k]) begin fails++; $display("FAIL short_byte%0d got %h want %h", k, cap[n0 + k], exp[k]); end
        end
    endtask

    task automatic test_overflow_image();
        logic [7:0] exp [5] = '{8'hA5, 8'h84, 8'h00, 8'h32, 8'h13};
        int n0 = ncap;
        int f0 = fd_cnt;
        bit ok;
        img = '{1, 2, 3, 4, 50, 5, 6, 7, 8, 9, 60, 100, 0, 0, 0, 0};
        drive_image(12);
        wait_frame(f0, ok);
        tests++; if (!ok) begin fails++; $display("FAIL ovf_timeout frame_done count %0d want %0d", fd_cnt, f0 + 1); end
        repeat (5) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            tests++; if (cap[n0 + k] !== exp[k]) begin fails++; $display("FAIL ovf_byte%0d got %h want %h", k, cap[n0 + k], exp[k]); end
        end
    endtask

    task automatic test_ignored_inputs();
        logic [7:0] exp [5] = '{8'hA5, 8'h02, 8'h00, 8'h07, 8'hA0};
        int n0 = ncap;
        int f0 = fd_cnt;
        bit ok;
        @(negedge clk); stray_done = 1'b1;
        @(negedge clk); stray_done = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (bus.busy !== 1'b0 || ncap !== n0) begin fails++; $display("FAIL stray_done_accum busy=%b trmts=%0d want 0/0", bus.busy, ncap - n0); end
        img = '{-5, 3, 7, 7, -1, 0, 2, 6, 1, -8, 0, 0, 0, 0, 0, 0};
        drive_image(10);
        // tx_done coincident with the first trmt must not advance the frame
        stray_done = 1'b1;
        @(negedge clk); stray_done = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            bus.score_vld  = 1'b1;
            bus.score      = SW'(30000);
            bus.score_last = 1'b1;
            @(negedge clk);
        end
        bus.score_vld  = 1'b0;
        bus.score_last = 1'b0;
        tests++; if (ncap - n0 !== 1) begin fails++; $display("FAIL same_cycle_done trmts=%0d want 1", ncap - n0); end
        wait_frame(f0, ok);
        tests++; if (!ok) begin fails++; $display("FAIL ign_timeout frame_done count %0d want %0d", fd_cnt, f0 + 1); end
        repeat (60) @(negedge clk);
        tests++; if (ncap - n0 !== 5) begin fails++; $display("FAIL ign_trmt_count got %0d want 5", ncap - n0); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL ign_idle_busy got %b want 0", bus.busy); end
        for (int k = 0; k < 5; k++) begin
            tests++; if (cap[n0 + k] !== exp[k]) begin fails++; $display("FAIL ign_byte%0d got %h want %h", k, cap[n0 + k], exp[k]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] exp [5] = '{8'hA5, 8'h02, 8'h00, 8'h07, 8'hA0};
        int n0 = ncap;
        int f0;
        bit ok = 1'b0;
        img = '{-5, 3, 7, 7, -1, 0, 2, 6, 1, -8, 0, 0, 0, 0, 0, 0};
        drive_image(10);
        for (int k = 0; k < 200; k++) begin
            if (ncap >= n0 + 2) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tests++; if (!ok) begin fails++; $display("FAIL rst_mid_timeout trmts=%0d want 2", ncap - n0); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        tests++; if (bus.trmt !== 1'b0 || bus.busy !== 1'b0 || bus.tx_data !== 8'h00 || bus.frame_done !== 1'b0)
            begin fails++; $display("FAIL rst_mid_outputs trmt=%b busy=%b data=%h fd=%b want 0/0/00/0", bus.trmt, bus.busy, bus.tx_data, bus.frame_done); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        tests++; if (ncap - n0 !== 2) begin fails++; $display("FAIL rst_mid_no_trmt trmts=%0d want 2", ncap - n0); end
        n0 = ncap;
        f0 = fd_cnt;
        drive_image(10);
        wait_frame(f0, ok);
        tests++; if (!ok) begin fails++; $display("FAIL rst_fresh_timeout frame_done count %0d want %0d", fd_cnt, f0 + 1); end
        repeat (5) @(negedge clk);
        tests++; if (ncap - n0 !== 5) begin fails++; $display("FAIL rst_fresh_trmt_count got %0d want 5", ncap - n0); end
        for (int k = 0; k < 5; k++) begin
            tests++; if (cap[n0 + k] !== exp[k]) begin fails++; $display("FAIL rst_fresh_byte%0d got %h want %h", k, cap[n0 + k], exp[k]); end
        end
    endtask

    initial begin
        bus.score_vld  = 1'b0;
        bus.score      = '0;
        bus.score_last = 1'b0;
        test_reset();
        test_basic_frame();
        test_most_negative();
        test_short_image();
        test_overflow_image();
        test_ignored_inputs();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

endmodule

// File: doc/cnn_result_tx.md
Name: cnn_result_tx

Overview:
- Downstream stage of the CNN core.
- Consumes the per-class score stream from the core's final layer and keeps a running signed argmax.
- On the last score, serialises a fixed 5-byte result frame to the UART transmitter one byte at a time using the trmt/tx_done handshake.
- Pulses frame_done when the frame is complete; the top level uses this pulse to clear its input-RAM write/read address counters for the next image.

Parameters:
- NUM_CLASSES, 10, scores per image; 2..128.
- SCORE_W, 16, signed score width; 2..16, sign-extended to 16 bits in the frame.
- HDR_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- score_vld  input  1  score/score_last valid this cycle.
- score  input  SCORE_W  signed class score.
- score_last  input  1  final score of the image; qualified by score_vld.
- busy  output  1  high while not accepting scores, i.e. in every state except ACCUM.
- trmt  output  1  one-cycle pulse requesting the UART to send tx_data.
- tx_data  output  8  byte to transmit.
- tx_done  input  1  one-cycle pulse from the UART when the byte has finished.
- frame_done  output  1  one-cycle pulse after the last frame byte completes.

Behaviour:
- Reset state (async, rst=1): ACCUM, count=0, err=0, best_idx=0, best_val=0; outputs busy=0, trmt=0, tx_data=8'h00, frame_done=0.
- Reset mid-frame aborts immediately; no further trmt is issued.
- States: ACCUM -> SEND -> WAIT -> (SEND | FIN) -> ACCUM.
- ACCUM, score acceptance (score_vld=1):
  - count==0: best_val=score, best_idx=0.
  - Otherwise, when count<NUM_CLASSES: replace best only if score > best_val (signed, strictly greater); ties keep the lower index.
  - count increments, saturating at NUM_CLASSES.
  - Scores arriving when count>=NUM_CLASSES are ignored for argmax and set err.
- ACCUM, end of image: score_vld & score_last (that score is included) -> SEND.
  - If the final count != NUM_CLASSES, set err.
  - Freeze the frame into 4 registered bytes.
- Frame bytes, in order:
  - B0 = HDR_BYTE.
  - B1 = {err, best_idx zero-extended to 7 bits}.
  - B2 = sext16(best_val)[15:8].
  - B3 = sext16(best_val)[7:0].
  - B4 = B0^B1^B2^B3.
- SEND: trmt=1 for exactly one cycle with tx_data = current byte; byte_cnt holds the current byte index -> WAIT.
  - Latency: score_last accepted on cycle N gives trmt with B0 on cycle N+1.
- WAIT: tx_data held stable until tx_done.
  - On tx_done: if byte_cnt==4 -> FIN; otherwise byte_cnt+1 -> SEND, so the next trmt comes the cycle after tx_done.
- FIN: frame_done=1 for one cycle; clear count, err and byte_cnt -> ACCUM. Scores are accepted again the following cycle.
- Ignored inputs:
  - score_vld while busy=1 is dropped; the upstream is required to stall on busy.
  - tx_done outside WAIT is ignored.
  - tx_done in the same cycle as trmt is ignored; the UART cannot finish in 0 cycles.
- busy is registered and is 1 from the cycle after score_last is accepted through the FIN cycle inclusive.

Decomposition:
- Shared package cnn_pkg holds:
  - state enum (ACCUM, SEND, WAIT, FIN);
  - FRAME_LEN=5;
  - default HDR_BYTE;
  - CLS_IDX_W = $clog2(NUM_CLASSES) helper.
- One sub-module, cnn_argmax:
  - contains the running signed compare, the best_idx/best_val registers, the saturating count and err;
  - inputs: clr, vld, score;
  - outputs: best_idx, best_val, count, err.
- cnn_result_tx holds the FSM, frame registers and checksum.

Test Plan:
- Scores 0..9 = {-5,3,7,7,-1,0,2,6,1,-8}, last on the 10th; UART model returns tx_done 20 cycles after each trmt -> bytes A5,02,00,07,A0; exactly 5 trmt pulses; frame_done one cycle after the 5th tx_done.
- All scores = 16'h8000 (most negative) -> idx 0; bytes A5,00,80,00,25.
- score_last on the 8th score, max 16'h0123 at index 4 -> err=1; bytes A5,84,01,23,03.
- 12 scores with the largest (100) at index 11, last on the 12th -> index 11 ignored, err=1; B1 = 80|argmax of the first 10.
- score_vld pulses while busy, plus stray tx_done in ACCUM -> no change to the frame or the state.
- rst asserted in WAIT after the 2nd byte -> trmt=0, busy=0, tx_data=00 immediately; a fresh 10-score image then produces a correct full frame.
